// File: rtl/decode.sv
// decode: second pipeline stage -- decodes fetch words, reads the register file, resolves JMP/BEZ/BNZ/HALT.
// Rev 1.0. Optional DECODE_WB_BYPASS_EN forwards same-cycle writeback data to operand/condition reads.
`default_nettype none

module decode #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RF_AW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       bjinst,
  input  logic [ADDR_W-1:0] nxtadrsr,
  input  logic              wb_we,
  input  logic [RF_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] PCd,
  output logic              bj,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [RF_AW-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [7:0]        ex_imm,
  output logic [ADDR_W-1:0] ex_pc,
  output logic              halted
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEZ  = 4'h9;
  localparam logic [3:0] OP_BNZ  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [0:0] {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t              state_q;
  logic                halted_q;
  logic [ADDR_W-1:0]   halt_pc_q;
  logic [15:0]         id_inst_q;
  logic [ADDR_W-1:0]   id_pc_q;
  logic [DATA_W-1:0]   rf_q [2**RF_AW];

  logic                ex_valid_q, ex_valid_d;
  logic [3:0]          ex_op_q, ex_op_d;
  logic [RF_AW-1:0]    ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0]   ex_a_q, ex_a_d;
  logic [DATA_W-1:0]   ex_b_q, ex_b_d;
  logic [7:0]          ex_imm_q, ex_imm_d;
  logic [ADDR_W-1:0]   ex_pc_q, ex_pc_d;

  logic [3:0]          op;
  logic [RF_AW-1:0]    rd, rs, rt;
  logic [7:0]          imm;
  logic [DATA_W-1:0]   rs_val, rt_val, cond_val;

  assign op  = id_inst_q[15:12];
  assign rd  = id_inst_q[11:9];
  assign rs  = id_inst_q[8:6];
  assign rt  = id_inst_q[5:3];
  assign imm = id_inst_q[7:0];

  // Branch condition register shares the rd field.
  assign rs_val   = (BYPASS && wb_we && wb_addr == rs) ? wb_data : rf_q[rs];
  assign rt_val   = (BYPASS && wb_we && wb_addr == rt) ? wb_data : rf_q[rt];
  assign cond_val = (BYPASS && wb_we && wb_addr == rd) ? wb_data : rf_q[rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**RF_AW; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      halted_q  <= 1'b0;
      halt_pc_q <= '0;
    end else if (state_q == S_RUN && op == OP_HALT) begin
      state_q   <= S_HALT;
      halted_q  <= 1'b1;
      halt_pc_q <= id_pc_q;
    end
  end

  always_comb begin
    bj  = 1'b0;
    PCd = id_pc_q + ADDR_W'(1);
    if (state_q == S_HALT) begin
      bj  = 1'b1;
      PCd = halt_pc_q;
    end else begin
      case (op)
        OP_JMP:  bj = 1'b1;
        OP_BEZ:  bj = (cond_val == '0);
        OP_BNZ:  bj = (cond_val != '0);
        default: bj = 1'b0;
      endcase
      if (op == OP_HALT) begin
        bj  = 1'b1;
        PCd = id_pc_q;
      end else if (bj) begin
        PCd = ADDR_W'(imm);
      end
    end
  end

  always_comb begin
    ex_valid_d = (state_q == S_RUN) && (op inside {[OP_ADD:OP_ST]});
    ex_op_d    = op;
    ex_rd_d    = rd;
    ex_a_d     = rs_val;
    ex_b_d     = (op == OP_LI) ? {{(DATA_W-8){1'b0}}, imm} : rt_val;
    ex_imm_d   = imm;
    ex_pc_d    = id_pc_q;
  end

  // D holds its word in HALT so the latched state stays coherent until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst_q  <= '0;
      id_pc_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
    end else begin
      if (state_q == S_RUN) begin
        id_inst_q <= bjinst;
        id_pc_q   <= nxtadrsr;
      end
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc_q    <= ex_pc_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_op_q;
  assign ex_rd    = ex_rd_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_imm   = ex_imm_q;
  assign ex_pc    = ex_pc_q;
  assign halted   = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// tb_decode: scoreboard bench for decode; expected EX bundles queue up one cycle ahead of the DUT.
`default_nettype none

module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bjinst;
  logic [7:0]  nxtadrsr;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [7:0]  PCd;
  logic        bj;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd;
  logic [15:0] ex_a, ex_b;
  logic [7:0]  ex_imm, ex_pc;
  logic        halted;

  decode dut (
    .clk(clk), .rst(rst), .bjinst(bjinst), .nxtadrsr(nxtadrsr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .PCd(PCd), .bj(bj), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a, b;
    logic [7:0]  imm, pc;
  } ex_t;

  ex_t         sb[$];
  int          n_chk = 0;
  int          n_fail = 0;

  logic [15:0] m_rf [8];
  logic [15:0] m_id;
  logic [7:0]  m_pc, m_hpc;
  logic        m_halt, m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mrd(input logic [2:0] idx);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && wb_addr == idx) return wb_data;
`endif
    return m_rf[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_id = 16'h0; m_pc = 8'h0; m_hpc = 8'h0; m_halt = 1'b0; m_halted = 1'b0;
    sb.delete();
    sb.push_back('{v: 1'b0, op: 4'h0, rd: 3'h0, a: 16'h0, b: 16'h0, imm: 8'h0, pc: 8'h0});
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic [15:0] inst, input logic [7:0] pc,
                      input logic we, input logic [2:0] wa, input logic [15:0] wd);
    logic [3:0]  op;
    logic [15:0] cnd;
    logic        ebj;
    logic [7:0]  epc;
    ex_t         e, n;
    bjinst = inst; nxtadrsr = pc; wb_we = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    op  = m_id[15:12];
    cnd = mrd(m_id[11:9]);
    epc = m_pc + 8'd1;
    ebj = 1'b0;
    if (m_halt) begin
      ebj = 1'b1; epc = m_hpc;
    end else begin
      case (op)
        4'h8: begin ebj = 1'b1; epc = m_id[7:0]; end
        4'h9: if (cnd == 16'h0) begin ebj = 1'b1; epc = m_id[7:0]; end
        4'hA: if (cnd != 16'h0) begin ebj = 1'b1; epc = m_id[7:0]; end
        4'hF: begin ebj = 1'b1; epc = m_pc; end
        default: ;
      endcase
    end
    check("bj", bj, ebj);
    check("PCd", PCd, epc);
    check("halted", halted, m_halted);
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("ex_valid", ex_valid, e.v);
      if (e.v) begin
        check("ex_op", ex_op, e.op);
        check("ex_rd", ex_rd, e.rd);
        check("ex_a", ex_a, e.a);
        check("ex_b", ex_b, e.b);
        check("ex_imm", ex_imm, e.imm);
        check("ex_pc", ex_pc, e.pc);
      end
    end
    n.v   = !m_halt && op >= 4'h1 && op <= 4'h7;
    n.op  = op;
    n.rd  = m_id[11:9];
    n.a   = mrd(m_id[8:6]);
    n.b   = (op == 4'h5) ? {8'h00, m_id[7:0]} : mrd(m_id[5:3]);
    n.imm = m_id[7:0];
    n.pc  = m_pc;
    sb.push_back(n);
    @(posedge clk);
    if (!m_halt && op == 4'hF) begin
      m_halt = 1'b1; m_halted = 1'b1; m_hpc = m_pc;
      m_id = inst; m_pc = pc;
    end else if (!m_halt) begin
      m_id = inst; m_pc = pc;
    end
    if (we) m_rf[wa] = wd;
    #1;
  endtask

  task automatic issue(input logic [15:0] inst, input logic [7:0] pc);
    step(inst, pc, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic wr(input logic [2:0] wa, input logic [15:0] wd);
    step(16'h0000, 8'h00, 1'b1, wa, wd);
  endtask

  // Called at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic apply_reset();
    bjinst = 16'h0; nxtadrsr = 8'h0; wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
    rst = 1'b1;
    #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_bj", bj, 1'b0);
    check("rst_PCd", PCd, 8'h01);
    check("rst_halted", halted, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] ri;
    rst = 1'b1;
    bjinst = 16'h0; nxtadrsr = 8'h0; wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
    @(posedge clk); #1;
    apply_reset();

    // Reset mid-run clears a live register.
    wr(3'd3, 16'h1234);
    issue(16'h12D8, 8'h05);
    issue(16'h0000, 8'h06);
    check("t1_pre_r3", ex_a, 16'h1234);
    apply_reset();
    issue(16'h12D8, 8'h07);
    issue(16'h0000, 8'h08);
    check("t1_r3_cleared", ex_a, 16'h0000);

    // ALU decode
    wr(3'd1, 16'd5);
    wr(3'd2, 16'd3);
    issue(16'h1250, 8'h10);
    issue(16'h0000, 8'h11);
    check("t2_valid", ex_valid, 1'b1);
    check("t2_op", ex_op, 4'h1);
    check("t2_rd", ex_rd, 3'd1);
    check("t2_a", ex_a, 16'd5);
    check("t2_b", ex_b, 16'd3);
    check("t2_pc", ex_pc, 8'h10);
    issue(16'h5AFE, 8'h12);
    issue(16'h0000, 8'h13);
    check("li_zext", ex_b, 16'h00FE);

    // Jump: one-cycle redirect
    issue(16'h8040, 8'h20);
    check("t3_bj", bj, 1'b1);
    check("t3_PCd", PCd, 8'h40);
    issue(16'h0000, 8'h21);
    check("t3_bj_clear", bj, 1'b0);

    // Branches, including a not-taken wrap at 0xFF
    wr(3'd2, 16'h0000);
    issue(16'h0000, 8'h22);
    issue(16'h9420, 8'h23);
    check("t4_bez_taken", bj, 1'b1);
    check("t4_bez_PCd", PCd, 8'h20);
    wr(3'd2, 16'd7);
    issue(16'h0000, 8'h24);
    issue(16'h9420, 8'hFF);
    check("t4_bez_nt", bj, 1'b0);
    check("t4_wrap", PCd, 8'h00);
    issue(16'hA420, 8'h25);
    check("t4_bnz_taken", bj, 1'b1);
    check("t4_bnz_PCd", PCd, 8'h20);
    issue(16'hB123, 8'h26);
    issue(16'h0000, 8'h27);

    // Random traffic, no HALT
    for (int k = 0; k < 80; k++) begin
      ri = 16'($urandom);
      if (ri[15:12] == 4'hF) ri[15:12] = 4'h0;
      step(ri, 8'($urandom), 1'($urandom), 3'($urandom), 16'($urandom_range(0, 3)));
    end
    issue(16'h0000, 8'h30);
    issue(16'h0000, 8'h31);

    // Halt is absorbing; writeback still accepted
    issue(16'hF000, 8'h33);
    check("t5_bj", bj, 1'b1);
    check("t5_PCd", PCd, 8'h33);
    for (int k = 0; k < 20; k++) step(16'h1250, 8'(8'h40 + k), 1'b1, 3'd5, 16'(k));
    check("t5_hold_PCd", PCd, 8'h33);
    check("t5_halted", halted, 1'b1);
    apply_reset();
    check("t5_rst_halted", halted, 1'b0);

    // Same-cycle writeback vs branch condition
    wr(3'd2, 16'd9);
    issue(16'h0000, 8'h50);
    issue(16'hA420, 8'h51);
    wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'h0;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    check("t6_bypass_bj", bj, 1'b0);
`else
    check("t6_bypass_bj", bj, 1'b1);
`endif
    step(16'h0000, 8'h52, 1'b1, 3'd2, 16'h0);
    issue(16'h0000, 8'h53);
    issue(16'h0000, 8'h54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
